// File: rtl/brute_force_sequencer_if.sv
// Candidate/result handshake between a brute-force sequencer lane and its
// hash/compare unit.
interface brute_force_sequencer_if #(
  parameter int NUM_CHARS = 4
) ();
  logic                   cand_valid;
  logic                   cand_ready;
  logic [8*NUM_CHARS-1:0] candidate;
  logic                   result_valid;
  logic                   match;

  modport master (
    output cand_valid,
    output candidate,
    input  cand_ready,
    input  result_valid,
    input  match
  );

  modport slave (
    input  cand_valid,
    input  candidate,
    output cand_ready,
    output result_valid,
    output match
  );
endinterface

// File: rtl/brute_force_sequencer.sv
// One brute-force lane: letter odometer that issues candidate words, waits for
// each compare result, and stops on the first match or when its share runs out.
module brute_force_sequencer #(
  parameter int NUM_CHARS = 4,
  parameter int NUM_LANES = 1,
  parameter int LANE_ID   = 0
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic                       abort,
  brute_force_sequencer_if.master    cand,
  output logic                       busy,
  output logic                       done,
  output logic                       found,
  output logic [8*NUM_CHARS-1:0]     found_word,
  output logic [31:0]                cand_count
);

  if (NUM_CHARS < 1 || NUM_CHARS > 8) begin : g_bad_chars
    $error("brute_force_sequencer: NUM_CHARS must be 1..8");
  end
  if (NUM_LANES < 1 || NUM_LANES > 7) begin : g_bad_lanes
    $error("brute_force_sequencer: NUM_LANES must be 1..7");
  end
  if (LANE_ID < 0 || LANE_ID >= NUM_LANES) begin : g_bad_lane_id
    $error("brute_force_sequencer: LANE_ID must be 0..NUM_LANES-1");
  end

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t     state;
  state_t     state_nxt;
  logic [4:0] dig     [NUM_CHARS];
  logic [4:0] dig_adv [NUM_CHARS];
  logic [5:0] sum0;
  logic       carry;
  logic       last_cand;
  logic       launch;
  logic       accept;
  logic       result;

  // abort takes priority over every other same-cycle event
  assign launch = (state == S_IDLE || state == S_DONE) && start && !abort;
  assign accept = (state == S_ISSUE) && cand.cand_ready && !abort;
  assign result = (state == S_WAIT) && cand.result_valid && !abort;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (launch) state_nxt = S_ISSUE;
      S_ISSUE: if (abort) state_nxt = S_IDLE;
               else if (accept) state_nxt = S_WAIT;
      S_WAIT:  if (abort) state_nxt = S_IDLE;
               else if (result) state_nxt = (cand.match || last_cand) ? S_DONE : S_ISSUE;
      S_DONE:  if (abort) state_nxt = S_IDLE;
               else if (launch) state_nxt = S_ISSUE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cand.cand_valid = (state == S_ISSUE);
    busy            = (state == S_ISSUE) || (state == S_WAIT);
    done            = (state == S_DONE);
  end

  // Digit 0 strides by NUM_LANES from LANE_ID; higher digits count 0..25 with carry.
  always_comb begin
    sum0       = {1'b0, dig[0]} + 6'(NUM_LANES);
    carry      = (sum0 > 6'd25);
    last_cand  = carry;
    dig_adv[0] = carry ? 5'(LANE_ID) : sum0[4:0];
    for (int k = 1; k < NUM_CHARS; k++) begin
      last_cand  = last_cand && (dig[k] == 5'd25);
      dig_adv[k] = dig[k];
      if (carry) begin
        if (dig[k] == 5'd25) begin
          dig_adv[k] = 5'd0;
        end else begin
          dig_adv[k] = dig[k] + 5'd1;
          carry      = 1'b0;
        end
      end
    end
  end

  for (genvar k = 0; k < NUM_CHARS; k++) begin : g_letter
    assign cand.candidate[8*k +: 8] = 8'h61 + {3'b000, dig[k]};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NUM_CHARS; k++) dig[k] <= 5'd0;
      found      <= 1'b0;
      found_word <= '0;
      cand_count <= '0;
    end else begin
      if (launch) begin
        for (int k = 0; k < NUM_CHARS; k++) dig[k] <= (k == 0) ? 5'(LANE_ID) : 5'd0;
        found      <= 1'b0;
        found_word <= '0;
        cand_count <= '0;
      end
      if (accept && cand_count != 32'hFFFF_FFFF) cand_count <= cand_count + 32'd1;
      if (result) begin
        if (cand.match) begin
          found      <= 1'b1;
          found_word <= cand.candidate;
        end else if (!last_cand) begin
          for (int k = 0; k < NUM_CHARS; k++) dig[k] <= dig_adv[k];
        end
      end
    end
  end

endmodule
